// File: rtl/dtb_pkg.sv
// Shared types and sizing for the trace buffer arbiter slice.
package dtb_pkg;
    localparam int TRB_DEPTH = 16;
    localparam int TRB_WIDTH = 32;
    localparam int PW        = $clog2(TRB_DEPTH);

    typedef logic [TRB_WIDTH-1:0] trb_word_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_RUN   = 2'd1,
        ARB_DRAIN = 2'd2,
        ARB_FLUSH = 2'd3
    } arbiter_state_t;

    typedef struct packed {
        arbiter_state_t state;
        logic [PW:0]    fill;
        logic           full;
        logic           empty;
        logic           overflow;
        logic           underflow;
    } status_t;

    function automatic status_t pack_status(
        input arbiter_state_t state,
        input logic [PW:0]    fill,
        input logic           full,
        input logic           empty,
        input logic           overflow,
        input logic           underflow
    );
        status_t s;
        s.state     = state;
        s.fill      = fill;
        s.full      = full;
        s.empty     = empty;
        s.overflow  = overflow;
        s.underflow = underflow;
        return s;
    endfunction
endpackage

// File: rtl/trb_arbiter_if.sv
// Logger-facing control/status bundle of the trace buffer arbiter.
interface trb_arbiter_if;
    import dtb_pkg::*;

    logic           enable;
    logic           clear;
    logic           write;
    logic           read;
    logic           rw_turn;
    logic           write_allow;
    logic           read_allow;
    logic [PW:0]    fill;
    logic           full;
    logic           empty;
    logic           overflow;
    logic           underflow;
    arbiter_state_t state;

    modport master (
        output enable, clear, write, read,
        input  rw_turn, write_allow, read_allow, fill, full, empty,
               overflow, underflow, state
    );

    modport slave (
        input  enable, clear, write, read,
        output rw_turn, write_allow, read_allow, fill, full, empty,
               overflow, underflow, state
    );
endinterface

// File: rtl/trb_fill_counter.sv
// Occupancy counter for the trace buffer; caller guarantees inc only when not full.
module trb_fill_counter
    import dtb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        dec,
    input  logic        clr,
    output logic [PW:0] count,
    output logic        full,
    output logic        empty
);
    localparam logic [PW:0] ONE   = (PW+1)'(1);
    localparam logic [PW:0] DEPTH = (PW+1)'(TRB_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + ONE;
        end else if (dec && !inc) begin
            count <= count - ONE;
        end
    end

    assign full  = (count == DEPTH);
    assign empty = (count == '0);
endmodule

// File: rtl/trb_arbiter.sv
// Trace buffer arbiter: sequences logger access to a single-port buffer.
//   state | meaning
//   IDLE  | tracing off, no access, port turn on write
//   RUN   | tracing on, port turn alternates write/read every cycle
//   DRAIN | tracing off, remaining words read out, writes blocked
//   FLUSH | one-cycle discard of buffer contents and error flags
module trb_arbiter
    import dtb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    trb_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        rw_turn_q, rw_turn_d;
    logic        ovf_q, unf_q;
    logic [PW:0] fill;
    logic        full, empty;
    logic        in_run, in_active;
    logic        write_allow, read_allow;
    logic        wr_acc, rd_acc;
    logic        wr_err, rd_err;

    assign in_run      = (state_q == S_RUN);
    assign in_active   = in_run || (state_q == S_DRAIN);
    assign write_allow = in_run && !full;
    assign read_allow  = in_active && !empty;

    assign wr_acc = bus.write && write_allow;
    assign rd_acc = bus.read && read_allow;
    assign wr_err = bus.write && !write_allow && in_run;
    assign rd_err = bus.read && !read_allow && in_active;

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.enable) state_d = S_RUN;
                S_RUN:   if (!bus.enable) state_d = empty ? S_IDLE : S_DRAIN;
                S_DRAIN: begin
                    if (bus.enable)  state_d = S_RUN;
                    else if (empty)  state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Every fresh entry into RUN starts on a write turn.
    always_comb begin
        rw_turn_d = 1'b0;
        case (state_d)
            S_RUN:   rw_turn_d = in_run ? ~rw_turn_q : 1'b0;
            S_DRAIN: rw_turn_d = 1'b1;
            default: rw_turn_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rw_turn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rw_turn_q <= rw_turn_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.clear) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_err) ovf_q <= 1'b1;
            if (rd_err) unf_q <= 1'b1;
        end
    end

    trb_fill_counter u_fill (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_acc),
        .dec   (rd_acc),
        .clr   (bus.clear),
        .count (fill),
        .full  (full),
        .empty (empty)
    );

    assign bus.rw_turn     = rw_turn_q;
    assign bus.write_allow = write_allow;
    assign bus.read_allow  = read_allow;
    assign bus.fill        = fill;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
    assign bus.state       = arbiter_state_t'(state_q);
endmodule

// File: tb/tb_trb_arbiter.sv
// Self-checking bench for trb_arbiter: directed scenarios plus random traffic vs. a reference model.
module tb_trb_arbiter;
    import dtb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    trb_arbiter_if bus ();

    trb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model, expressed as occupancy and a run-age counter.
    int             m_fill;
    arbiter_state_t m_state;
    int             m_run_age;
    bit             m_ovf, m_unf;

    task automatic model_reset();
        m_fill    = 0;
        m_state   = ARB_IDLE;
        m_run_age = 0;
        m_ovf     = 0;
        m_unf     = 0;
    endtask

    task automatic model_step(input bit en, input bit clr, input bit wr, input bit rd);
        bit run, act, wa, ra;
        arbiter_state_t ns;
        run = (m_state == ARB_RUN);
        act = run || (m_state == ARB_DRAIN);
        wa  = run && (m_fill < TRB_DEPTH);
        ra  = act && (m_fill > 0);
        ns  = m_state;
        if (clr) begin
            ns    = ARB_FLUSH;
            m_fill = 0;
            m_ovf  = 0;
            m_unf  = 0;
        end else begin
            case (m_state)
                ARB_IDLE:  if (en) ns = ARB_RUN;
                ARB_RUN:   if (!en) ns = (m_fill > 0) ? ARB_DRAIN : ARB_IDLE;
                ARB_DRAIN: if (en) ns = ARB_RUN; else if (m_fill == 0) ns = ARB_IDLE;
                default:   ns = ARB_IDLE;
            endcase
            m_fill = m_fill + ((wr && wa) ? 1 : 0) - ((rd && ra) ? 1 : 0);
            if (run && wr && !wa) m_ovf = 1;
            if (act && rd && !ra) m_unf = 1;
        end
        m_run_age = (ns == ARB_RUN && m_state == ARB_RUN) ? m_run_age + 1 : 0;
        m_state   = ns;
    endtask

    task automatic drive(input bit en, input bit clr, input bit wr, input bit rd);
        bus.enable = en;
        bus.clear  = clr;
        bus.write  = wr;
        bus.read   = rd;
        @(posedge clk);
        model_step(en, clr, wr, rd);
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (bus.state !== ARB_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", bus.state, ARB_IDLE); end
        checks++; if (bus.fill !== '0) begin failures++; $display("FAIL rst_fill got=%0d exp=0", bus.fill); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL rst_empty_full got=%b%b exp=10", bus.empty, bus.full); end
        checks++; if ({bus.write_allow, bus.read_allow, bus.rw_turn} !== 3'b000) begin failures++; $display("FAIL rst_allow_turn got=%b%b%b exp=000", bus.write_allow, bus.read_allow, bus.rw_turn); end
        checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", bus.overflow, bus.underflow); end
        rst_n = 1'b1;
        drive(0, 0, 1, 1);
        checks++; if (bus.state !== ARB_IDLE || bus.fill !== '0) begin failures++; $display("FAIL idle_ignore state=%0d fill=%0d exp state=0 fill=0", bus.state, bus.fill); end
        checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin failures++; $display("FAIL idle_noflag got=%b%b exp=00", bus.overflow, bus.underflow); end
    endtask

    task automatic test_run_toggle();
        drive(1, 0, 0, 0);
        checks++; if (bus.state !== ARB_RUN) begin failures++; $display("FAIL run_enter got=%0d exp=%0d", bus.state, ARB_RUN); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rw_turn !== 1'(i % 2)) begin failures++; $display("FAIL run_turn%0d got=%b exp=%0d", i, bus.rw_turn, i % 2); end
            drive(1, 0, 0, 0);
        end
        checks++; if (bus.empty !== 1'b1 || bus.read_allow !== 1'b0) begin failures++; $display("FAIL run_empty got=%b ra=%b exp=1 0", bus.empty, bus.read_allow); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) drive(1, 0, 1, 0);
        checks++; if (bus.fill !== 5'd16 || bus.full !== 1'b1) begin failures++; $display("FAIL full_fill got=%0d full=%b exp=16 1", bus.fill, bus.full); end
        checks++; if (bus.write_allow !== 1'b0) begin failures++; $display("FAIL full_wa got=%b exp=0", bus.write_allow); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL pre_ovf got=%b exp=0", bus.overflow); end
        drive(1, 0, 1, 0);
        checks++; if (bus.overflow !== 1'b1 || bus.fill !== 5'd16) begin failures++; $display("FAIL ovf got=%b fill=%0d exp=1 16", bus.overflow, bus.fill); end
    endtask

    task automatic test_simultaneous();
        drive(1, 0, 1, 1);
        checks++; if (bus.fill !== 5'd15) begin failures++; $display("FAIL wr_rd_full got=%0d exp=15", bus.fill); end
        for (int i = 0; i < 15; i++) drive(1, 0, 0, 1);
        checks++; if (bus.fill !== '0 || bus.underflow !== 1'b0) begin failures++; $display("FAIL drained got=%0d unf=%b exp=0 0", bus.fill, bus.underflow); end
        drive(1, 0, 1, 1);
        checks++; if (bus.fill !== 5'd1 || bus.underflow !== 1'b1) begin failures++; $display("FAIL wr_rd_empty got=%0d unf=%b exp=1 1", bus.fill, bus.underflow); end
    endtask

    task automatic test_drain();
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 0);
        checks++; if (bus.fill !== 5'd5) begin failures++; $display("FAIL drain_pre got=%0d exp=5", bus.fill); end
        drive(0, 0, 0, 0);
        checks++; if (bus.state !== ARB_DRAIN || bus.write_allow !== 1'b0) begin failures++; $display("FAIL drain_enter state=%0d wa=%b exp=2 0", bus.state, bus.write_allow); end
        checks++; if (bus.read_allow !== 1'b1 || bus.rw_turn !== 1'b1) begin failures++; $display("FAIL drain_ra_turn got=%b%b exp=11", bus.read_allow, bus.rw_turn); end
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1);
        checks++; if (bus.fill !== '0) begin failures++; $display("FAIL drain_fill got=%0d exp=0", bus.fill); end
        drive(0, 0, 0, 0);
        checks++; if (bus.state !== ARB_IDLE) begin failures++; $display("FAIL drain_idle got=%0d exp=0", bus.state); end
    endtask

    task automatic test_clear();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 17; i++) drive(1, 0, 1, 0);
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 1);
        checks++; if (bus.fill !== 5'd9 || bus.overflow !== 1'b1) begin failures++; $display("FAIL clr_pre got=%0d ovf=%b exp=9 1", bus.fill, bus.overflow); end
        drive(1, 1, 1, 1);
        checks++; if (bus.state !== ARB_FLUSH || bus.fill !== '0) begin failures++; $display("FAIL flush state=%0d fill=%0d exp=3 0", bus.state, bus.fill); end
        checks++; if ({bus.overflow, bus.underflow, bus.write_allow, bus.read_allow, bus.rw_turn} !== 5'b0) begin failures++; $display("FAIL flush_outs got=%b%b%b%b%b exp=00000", bus.overflow, bus.underflow, bus.write_allow, bus.read_allow, bus.rw_turn); end
        drive(1, 0, 0, 0);
        checks++; if (bus.state !== ARB_IDLE) begin failures++; $display("FAIL flush_idle got=%0d exp=0", bus.state); end
        drive(1, 0, 0, 0);
        checks++; if (bus.state !== ARB_RUN) begin failures++; $display("FAIL flush_run got=%0d exp=1", bus.state); end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 7; i++) drive(1, 0, 1, 0);
        checks++; if (bus.fill !== 5'd7) begin failures++; $display("FAIL mid_pre got=%0d exp=7", bus.fill); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.fill !== '0 || bus.empty !== 1'b1 || bus.state !== ARB_IDLE) begin failures++; $display("FAIL mid_rst fill=%0d empty=%b state=%0d exp=0 1 0", bus.fill, bus.empty, bus.state); end
        checks++; if ({bus.write_allow, bus.read_allow, bus.rw_turn, bus.full} !== 4'b0) begin failures++; $display("FAIL mid_rst_outs got=%b%b%b%b exp=0000", bus.write_allow, bus.read_allow, bus.rw_turn, bus.full); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0);
        checks++; if (bus.state !== ARB_RUN || bus.rw_turn !== 1'b0 || bus.fill !== '0) begin failures++; $display("FAIL mid_rerun state=%0d turn=%b fill=%0d exp=1 0 0", bus.state, bus.rw_turn, bus.fill); end
    endtask

    task automatic test_random();
        bit en, clr, wr, rd;
        logic [PW:0] exp_fill;
        bit exp_turn, exp_wa, exp_ra;
        en = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) en = ~en;
            clr = ($urandom_range(0, 59) == 0);
            wr  = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rd  = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive(en, clr, wr, rd);
            exp_fill = m_fill[PW:0];
            exp_turn = (m_state == ARB_RUN) ? ((m_run_age % 2) == 1) : (m_state == ARB_DRAIN);
            exp_wa   = (m_state == ARB_RUN) && (m_fill < TRB_DEPTH);
            exp_ra   = (m_state == ARB_RUN || m_state == ARB_DRAIN) && (m_fill > 0);
            checks++;
            if (bus.fill !== exp_fill || bus.state !== m_state || bus.rw_turn !== exp_turn
                || bus.write_allow !== exp_wa || bus.read_allow !== exp_ra
                || bus.full !== (m_fill == TRB_DEPTH) || bus.empty !== (m_fill == 0)
                || bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
                failures++;
                $display("FAIL rand%0d got fill=%0d st=%0d turn=%b wa=%b ra=%b f=%b e=%b o=%b u=%b exp fill=%0d st=%0d turn=%b wa=%b ra=%b o=%b u=%b",
                         i, bus.fill, bus.state, bus.rw_turn, bus.write_allow, bus.read_allow, bus.full, bus.empty,
                         bus.overflow, bus.underflow, exp_fill, m_state, exp_turn, exp_wa, exp_ra, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.clear  = 1'b0;
        bus.write  = 1'b0;
        bus.read   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_run_toggle();
        test_fill_overflow();
        test_simultaneous();
        test_drain();
        test_clear();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
